fft_peak_search: RTL and testbench

Streaming spectral peak detector downstream of the burst FFT/IFFT core's output port. It consumes one complete output frame (bin data plus bin index), computes the squared magnitude of every bin and tracks the largest one. At frame end it presents a single result (peak index, peak power, bin count) on a valid/ready handshake. Stalls its input while the result is pending, so no frame is ever merged or lost.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_cplx_power.sv | 56 +++++
 rtl/fft_peak_search.sv | 164 ++++++++++++++++
 tb/tb_fft_peak_search.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output-side spectral peak search.
package fft_pkg;

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    DRAIN  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 2;

  function automatic int unsigned pwr_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/fft_cplx_power.sv
// Two-stage squared-magnitude pipe (re^2, im^2 then sum) with valid and index sideband.
module fft_cplx_power
  import fft_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 16,
  parameter  int unsigned INDEX_WIDTH = 10,
  localparam int unsigned PWR_WIDTH   = pwr_width(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2*DATA_WIDTH-1:0]  in_data,
  input  logic [INDEX_WIDTH-1:0]   in_index,
  output logic                     out_valid,
  output logic [PWR_WIDTH-1:0]     out_power,
  output logic [INDEX_WIDTH-1:0]   out_index
);

  logic signed [PWR_WIDTH-1:0] re_ext_c;
  logic signed [PWR_WIDTH-1:0] im_ext_c;
  logic [PWR_WIDTH-1:0]        re_sq_c;
  logic [PWR_WIDTH-1:0]        im_sq_c;
  logic [PWR_WIDTH-1:0]        re_sq_q;
  logic [PWR_WIDTH-1:0]        im_sq_q;
  logic                        s1_valid;
  logic [INDEX_WIDTH-1:0]      s1_index;

  // Sign-extend to full width so the square is exact and non-negative
  always_comb begin
    re_ext_c = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data[DATA_WIDTH-1:0]};
    im_ext_c = {{DATA_WIDTH{in_data[2*DATA_WIDTH-1]}}, in_data[2*DATA_WIDTH-1:DATA_WIDTH]};
    re_sq_c  = $unsigned(re_ext_c * re_ext_c);
    im_sq_c  = $unsigned(im_ext_c * im_ext_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_index  <= '0;
      re_sq_q   <= '0;
      im_sq_q   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_power <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_index  <= in_index;
      re_sq_q   <= re_sq_c;
      im_sq_q   <= im_sq_c;
      out_valid <= s1_valid;
      out_index <= s1_index;
      out_power <= re_sq_q + im_sq_q;
    end
  end

endmodule

// File: rtl/fft_peak_search.sv
// Streaming peak-power search over one FFT output frame, result on a valid/ready port.
// Build option FFT_PEAK_SKIP_DC_EN: bin 0 is counted but never eligible as the peak.
module fft_peak_search
  import fft_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned ADDR_WIDTH = 9,
  localparam int unsigned PWR_WIDTH  = pwr_width(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*DATA_WIDTH-1:0] s_axi_data,
  input  logic [ADDR_WIDTH:0]     s_axi_user,
  input  logic                    s_axi_last,
  input  logic                    s_axi_valid,
  output logic                    s_axi_ready,
  output logic                    m_res_valid,
  input  logic                    m_res_ready,
  output logic [ADDR_WIDTH:0]     m_res_index,
  output logic [PWR_WIDTH-1:0]    m_res_power,
  output logic [ADDR_WIDTH+1:0]   m_res_count
);

  localparam int unsigned IDX_W   = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W   = ADDR_WIDTH + 2;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t               state;
  state_t               state_next;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [DRAIN_W-1:0]   drain_cnt_next;

  logic                    accept_c;
  logic                    handshake_c;
  logic                    eligible_c;
  logic                    load_c;

  logic                    in_valid_q;
  logic [2*DATA_WIDTH-1:0] in_data_q;
  logic [IDX_W-1:0]        in_index_q;

  logic                    pipe_valid;
  logic [PWR_WIDTH-1:0]    pipe_power;
  logic [IDX_W-1:0]        pipe_index;
  logic                    peak_seen;

  assign accept_c    = s_axi_valid & s_axi_ready;
  assign handshake_c = m_res_valid & m_res_ready;

  // Input register isolates upstream timing; it is the first of the three drain slots
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      in_index_q <= '0;
    end else begin
      in_valid_q <= accept_c;
      if (accept_c) begin
        in_data_q  <= s_axi_data;
        in_index_q <= s_axi_user;
      end
    end
  end

  fft_cplx_power #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (IDX_W)
  ) u_power (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_q),
    .in_data   (in_data_q),
    .in_index  (in_index_q),
    .out_valid (pipe_valid),
    .out_power (pipe_power),
    .out_index (pipe_index)
  );

`ifdef FFT_PEAK_SKIP_DC_EN
  assign eligible_c = pipe_valid && (pipe_index != '0);
`else
  assign eligible_c = pipe_valid;
`endif

  // Strict greater-than keeps the earliest bin on ties
  assign load_c = eligible_c && (!peak_seen || (pipe_power > m_res_power));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    unique case (state)
      ACC: begin
        if (accept_c && s_axi_last) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = RESULT;
        end else begin
          drain_cnt_next = drain_cnt - DRAIN_W'(1);
        end
      end
      RESULT: begin
        if (m_res_ready) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next     = ACC;
        drain_cnt_next = '0;
      end
    endcase
  end

  // Handshake registers follow the next state so they line up with the state change
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_ready <= 1'b0;
      m_res_valid <= 1'b0;
    end else begin
      s_axi_ready <= (state_next == ACC);
      m_res_valid <= (state_next == RESULT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_res_count <= '0;
    end else if (handshake_c) begin
      m_res_count <= '0;
    end else if (accept_c && (m_res_count != {CNT_W{1'b1}})) begin
      m_res_count <= m_res_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_seen   <= 1'b0;
      m_res_index <= '0;
      m_res_power <= '0;
    end else if (handshake_c) begin
      peak_seen   <= 1'b0;
      m_res_index <= '0;
      m_res_power <= '0;
    end else if (load_c) begin
      peak_seen   <= 1'b1;
      m_res_index <= pipe_index;
      m_res_power <= pipe_power;
    end
  end

endmodule

// File: tb/tb_fft_peak_search.sv
// Scoreboard bench for fft_peak_search: directed frames queue expected results, a monitor checks them.
module tb_fft_peak_search;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_data;
  logic [9:0]  s_axi_user;
  logic        s_axi_last;
  logic        s_axi_valid;
  logic        s_axi_ready;
  logic        m_res_valid;
  logic        m_res_ready;
  logic [9:0]  m_res_index;
  logic [31:0] m_res_power;
  logic [10:0] m_res_count;

  fft_peak_search dut (
    .clk         (clk),
    .rst         (rst),
    .s_axi_data  (s_axi_data),
    .s_axi_user  (s_axi_user),
    .s_axi_last  (s_axi_last),
    .s_axi_valid (s_axi_valid),
    .s_axi_ready (s_axi_ready),
    .m_res_valid (m_res_valid),
    .m_res_ready (m_res_ready),
    .m_res_index (m_res_index),
    .m_res_power (m_res_power),
    .m_res_count (m_res_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint pwr;
    longint cnt;
  } exp_t;

  exp_t sb[$];
  int   q_re[$];
  int   q_im[$];
  int   q_idx[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_acc_cyc = 0;
  int hs_cyc = 0;
  bit valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic bit elig(input int idx);
`ifdef FFT_PEAK_SKIP_DC_EN
    return idx != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input longint idx, input longint pwr, input longint cnt);
    exp_t e;
    e.idx = idx; e.pwr = pwr; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic add(input int re, input int im, input int idx);
    q_re.push_back(re); q_im.push_back(im); q_idx.push_back(idx);
  endtask

  // Expected result of the queued frame from a straightforward max search
  task automatic push_model();
    longint best_p = 0;
    longint best_i = 0;
    bit     seen = 0;
    longint cnt;
    for (int k = 0; k < q_re.size(); k++) begin
      longint p = longint'(q_re[k]) * q_re[k] + longint'(q_im[k]) * q_im[k];
      if (elig(q_idx[k]) && (!seen || p > best_p)) begin
        seen = 1; best_p = p; best_i = q_idx[k];
      end
    end
    cnt = (q_re.size() > 2047) ? 2047 : q_re.size();
    push(best_i, best_p, cnt);
  endtask

  task automatic beat(input int re, input int im, input int idx, input bit last);
    int w = 0;
    s_axi_data  = {16'(im), 16'(re)};
    s_axi_user  = 10'(idx);
    s_axi_last  = last;
    s_axi_valid = 1'b1;
    @(negedge clk);
    while (!s_axi_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (last) last_acc_cyc = cyc;
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
  endtask

  task automatic send_frame(input int bubble_pct);
    for (int k = 0; k < q_re.size(); k++) begin
      if (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
        @(posedge clk);
        #1;
      end
      beat(q_re[k], q_im[k], q_idx[k], k == q_re.size() - 1);
    end
    q_re.delete(); q_im.delete(); q_idx.delete();
  endtask

  task automatic wait_drained();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_wait", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every valid cycle is compared against the queue head
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (m_res_valid) begin
        if (!valid_prev) chk("valid_latency", cyc - last_acc_cyc, 3);
        chk("ready_low_while_result", s_axi_ready, 0);
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("res_index", m_res_index, sb[0].idx);
          chk("res_power", m_res_power, sb[0].pwr);
          chk("res_count", m_res_count, sb[0].cnt);
          if (m_res_ready) begin
            hs_cyc = cyc + 1;
            void'(sb.pop_front());
          end
        end
      end
      valid_prev = m_res_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_axi_data = '0; s_axi_user = '0; s_axi_last = 1'b0;
    s_axi_valid = 1'b0; m_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_axi_ready, 0);
    chk("rst_valid", m_res_valid, 0);
    chk("rst_index", m_res_index, 0);
    chk("rst_power", m_res_power, 0);
    chk("rst_count", m_res_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_rst", s_axi_ready, 1);
    @(posedge clk);
    #1;

    // Increasing powers, peak at bin 5 (300,400) -> 250000
    for (int k = 0; k < 8; k++) begin
      if (k == 5) add(300, 400, 5);
      else add(50 * k, 0, k);
    end
    push(5, 250000, 8);
    send_frame(0);
    wait_drained();

    // Full-scale tie at bins 2 and 6 -> 2^31, earliest bin wins
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 6) add(-32768, -32768, k);
      else add(k, -k, k);
    end
    push(2, 64'd2147483648, 8);
    send_frame(0);
    wait_drained();

    // Result held 10 cycles; next single-beat frame waits, permuted indices tolerated
    m_res_ready = 1'b0;
    add(7, 0, 3); add(0, 9, 1); add(-8, 0, 0); add(6, 6, 2);
    push(1, 81, 4);
    push(9, 74, 1);
    send_frame(0);
    fork
      begin
        int w = 0;
        while (!m_res_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        repeat (10) @(posedge clk);
        #1 m_res_ready = 1'b1;
      end
      begin
        beat(-5, 7, 9, 1'b1);
      end
    join
    chk("next_frame_after_handshake", acc_cyc, hs_cyc + 1);
    wait_drained();

    // Dominant DC bin
    add(1000, 0, 0); add(10, 0, 1); add(10, 0, 2); add(10, 0, 3);
`ifdef FFT_PEAK_SKIP_DC_EN
    push(1, 100, 4);
`else
    push(0, 1000000, 4);
`endif
    send_frame(0);
    wait_drained();

    // Partial frame killed by reset, then a clean frame with peak at bin 3
    for (int k = 0; k < 4; k++) beat(2000, 2000, k, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_count", m_res_count, 0);
    chk("midrst_ready", s_axi_ready, 0);
    chk("midrst_power", m_res_power, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) add(1000, 0, 3);
      else add(k + 1, 0, k);
    end
    push(3, 1000000, 8);
    send_frame(0);
    wait_drained();

    // 1024-bin random frame with input bubbles
    for (int k = 0; k < 1024; k++)
      add(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, k);
    push_model();
    send_frame(30);
    wait_drained();

    // Count saturation on an over-long frame of zero-power bins
    for (int k = 0; k < 2050; k++) add(0, 0, k % 1024);
`ifdef FFT_PEAK_SKIP_DC_EN
    push(1, 0, 2047);
`else
    push(0, 0, 2047);
`endif
    send_frame(0);
    wait_drained();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
